// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier with run-skipping:
// FSM state encoding, operand width, iteration count and a shift clamp.
package booth_pkg;

  localparam int WIDTH    = 16;
  localparam int CNT_INIT = 16;
  localparam int CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Largest no-add shift allowed this cycle: the run length, but never past
  // the number of multiplier bits still to be retired.
  function automatic logic [CNT_W-1:0] clamp_shift(input logic [3:0]       amt,
                                                   input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] amt_ext;
    amt_ext = {1'b0, amt};
    return (amt_ext < cnt) ? amt_ext : cnt;
  endfunction

endpackage

// File: rtl/shift_amount.sv
// Run-length detector for Booth skipping. Counts how many consecutive
// adjacent bit pairs, starting at bit 0, hold equal values; each such pair
// is a Booth step with no add/subtract, so they can be retired in one shift.
// The count saturates at 15 so it always fits the 4-bit amount field.
module shift_amount (
  input  logic [16:0] i_number,
  output logic [5:0]  o_amt
);

  logic [5:0] w_cnt;
  logic       w_run;

  // Walk up from bit 0 while neighbouring bits agree.
  always_comb begin
    w_cnt = 6'd0;
    w_run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (w_run && (i_number[i+1] == i_number[i])) begin
        w_cnt = w_cnt + 6'd1;
      end else begin
        w_run = 1'b0;
      end
    end
    o_amt = (w_cnt > 6'd15) ? 6'd15 : w_cnt;
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed 16x16 Booth multiplier. Each CALC cycle either performs
// one add/subtract step followed by a 1-bit arithmetic shift, or skips a run
// of identical multiplier bits with a multi-bit shift. The accumulator is one
// bit wider than the operands so that M = -32768 cannot overflow it.
module booth_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import booth_pkg::*;

  // Architectural state
  state_t                    r_state;
  logic signed [WIDTH:0]     r_a;
  logic signed [WIDTH:0]     r_m;
  logic [WIDTH-1:0]          r_q;
  logic                      r_q1;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_busy;
  logic                      r_done;
  logic [2*WIDTH-1:0]        r_product;

  // Datapath for one CALC cycle
  logic [WIDTH:0]            w_number;
  logic [5:0]                w_amt;
  logic [3:0]                w_amt_lo;
  logic                      w_unused_amt_hi;
  logic [1:0]                w_pair;
  logic                      w_add_step;
  logic signed [WIDTH:0]     w_a_sum;
  logic [CNT_W-1:0]          w_step;
  logic signed [2*WIDTH+1:0] w_acc;
  logic signed [2*WIDTH+1:0] w_acc_sh;
  logic signed [WIDTH:0]     w_a_next;
  logic [WIDTH-1:0]          w_q_next;
  logic                      w_q1_next;
  logic [CNT_W-1:0]          w_cnt_next;

  assign w_number = {r_q, r_q1};
  assign w_pair   = {r_q[0], r_q1};

  shift_amount u_shift_amount (
    .i_number (w_number),
    .o_amt    (w_amt)
  );

  // Only the low nibble steers the shifter; the detector saturates at 15,
  // so the upper bits carry no information here.
  assign w_amt_lo        = w_amt[3:0];
  assign w_unused_amt_hi = |w_amt[5:4];

  // Booth recoding of the current pair: 10 subtracts M, 01 adds M,
  // 00/11 leave the accumulator alone and allow a multi-bit skip.
  always_comb begin
    w_a_sum    = r_a;
    w_add_step = 1'b0;
    case (w_pair)
      2'b10: begin
        w_a_sum    = r_a - r_m;
        w_add_step = 1'b1;
      end
      2'b01: begin
        w_a_sum    = r_a + r_m;
        w_add_step = 1'b1;
      end
      default: begin
        w_a_sum    = r_a;
        w_add_step = 1'b0;
      end
    endcase
  end

  // An add/subtract step always retires exactly one bit; a skip retires the
  // whole run, clipped to the bits that remain.
  assign w_step = w_add_step ? CNT_W'(1) : clamp_shift(w_amt_lo, r_cnt);

  // Arithmetic right shift of the joint {A, Q, q_1} register.
  assign w_acc      = {w_a_sum, r_q, r_q1};
  assign w_acc_sh   = w_acc >>> w_step;
  assign w_a_next   = w_acc_sh[2*WIDTH+1:WIDTH+1];
  assign w_q_next   = w_acc_sh[WIDTH:1];
  assign w_q1_next  = w_acc_sh[0];
  assign w_cnt_next = r_cnt - w_step;

  // Control FSM with registered busy/done/product; the async reset clears
  // everything so an aborted multiply leaves no trace.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= '0;
            r_m     <= $signed({multiplicand[WIDTH-1], multiplicand});
            r_q     <= multiplier;
            r_q1    <= 1'b0;
            r_cnt   <= CNT_W'(CNT_INIT);
            r_busy  <= 1'b1;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_q1  <= w_q1_next;
          r_cnt <= w_cnt_next;
          if (w_cnt_next == '0) begin
            r_product <= {w_a_next[WIDTH-1:0], w_q_next};
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          // Start is not sampled here; the next request is taken in IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;

endmodule
